// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage occupancy states and reset constants.
package pipe_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [31:0] RST_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
endpackage

// File: rtl/pipe_skid_entry.sv
// Single payload register with load enable and synchronous clear.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr_i)
      q_q <= '0;
    else if (ld_i)
      q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: main entry plus one skid entry, flush,
// and a saturating backpressure stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W = 96,
  parameter logic [31:0] RST_PC = RST_PC_DEF,
  parameter int          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int BW = 64 + DATA_W;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_fire, out_fire;
  logic               sk_ld;
  logic [BW-1:0]      sk_d, sk_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign sk_d     = {in_pc, in_instr, in_data};

  pipe_skid_entry #(.W(BW)) u_skid (
    .clk   (clk),
    .clr_i (reset),
    .ld_i  (sk_ld),
    .d_i   (sk_d),
    .q_o   (sk_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      pc_q    <= RST_PC;
      instr_q <= NOP_INSTR;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    data_d  = data_q;
    sk_ld   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
      instr_d = NOP_INSTR;
      data_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            pc_d    = in_pc;
            instr_d = in_instr;
            data_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            pc_d    = in_pc;
            instr_d = in_instr;
            data_d  = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            sk_ld   = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
            instr_d = NOP_INSTR;
            data_d  = '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            pc_d    = sk_q[BW-1 -: 32];
            instr_d = sk_q[DATA_W+31 -: 32];
            data_d  = sk_q[DATA_W-1:0];
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL) & ~reset;
    out_valid = (state_q != EMPTY);
    occupancy = state_q;
  end

  // Saturates rather than wraps; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (out_valid && !out_ready && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush,
// reset mid-stream and stall counter saturation.
module tb_pipe_stage_reg;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .RST_PC (32'h0000_3000),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = pc ^ 32'hA5A5_0000;
    in_data  = {pc, ~pc, pc + 32'd1};
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    tick();
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_pc", out_pc, 32'h3000);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_data", out_data, 96'h0);
    chk("rst_stall", stall_cnt, 16'h0);
    chk("rst_inrdy", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_inrdy_after", in_ready, 1'b1);

    // Streaming
    out_ready = 1'b1;
    beat(32'h3000);
    tick();
    chk("str_pc0", out_pc, 32'h3000);
    chk("str_occ0", occupancy, 2'd1);
    chk("str_instr0", out_instr, 32'hA5A5_3000);
    chk("str_data0", out_data,
        {32'h3000, 32'hFFFF_CFFF, 32'h3001});
    beat(32'h3004);
    tick();
    chk("str_pc1", out_pc, 32'h3004);
    chk("str_occ1", occupancy, 2'd1);
    beat(32'h3008);
    tick();
    chk("str_pc2", out_pc, 32'h3008);
    chk("str_occ2", occupancy, 2'd1);
    in_valid = 1'b0;
    tick();
    chk("str_drain_valid", out_valid, 1'b0);
    chk("str_drain_instr", out_instr, 32'h0);
    chk("str_drain_data", out_data, 96'h0);
    chk("str_drain_pc", out_pc, 32'h3008);
    chk("str_stall", stall_cnt, 16'h0);

    // Backpressure
    out_ready = 1'b0;
    beat(32'h3000);
    tick();
    chk("bp_occ1", occupancy, 2'd1);
    beat(32'h3004);
    tick();
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_inrdy", in_ready, 1'b0);
    chk("bp_pc_hold", out_pc, 32'h3000);
    chk("bp_stall1", stall_cnt, 16'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_out0", out_pc, 32'h3000);
    tick();
    chk("bp_out1", out_pc, 32'h3004);
    chk("bp_out1_instr", out_instr, 32'hA5A5_3004);
    chk("bp_occ_back1", occupancy, 2'd1);
    tick();
    chk("bp_empty", out_valid, 1'b0);
    chk("bp_stall_final", stall_cnt, 16'd1);

    // Flush with both entries held and an incoming beat
    out_ready = 1'b0;
    beat(32'h3000);
    tick();
    beat(32'h3004);
    tick();
    chk("fl_occ2", occupancy, 2'd2);
    beat(32'h300C);
    flush = 1'b1;
    tick();
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_instr", out_instr, 32'h0);
    chk("fl_data", out_data, 96'h0);
    chk("fl_pc", out_pc, 32'h3000);
    chk("fl_stall_kept", stall_cnt, 16'd3);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_300c", out_valid, 1'b0);
    end

    // Flush beats an accepted beat while EMPTY
    beat(32'h3010);
    flush = 1'b1;
    #1;
    chk("fl2_inrdy", in_ready, 1'b1);
    tick();
    chk("fl2_occ", occupancy, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;

    // Reset mid-stream
    out_ready = 1'b0;
    beat(32'h3018);
    tick();
    beat(32'h301C);
    tick();
    chk("rm_occ2", occupancy, 2'd2);
    chk("rm_stall", stall_cnt, 16'd4);
    beat(32'h3020);
    reset = 1'b1;
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rm_inrdy_rst", in_ready, 1'b0);
    tick();
    chk("rm_pc", out_pc, 32'h3000);
    chk("rm_valid", out_valid, 1'b0);
    chk("rm_stall0", stall_cnt, 16'h0);
    chk("rm_occ0", occupancy, 2'd0);
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rm_inrdy_after", in_ready, 1'b1);

    // Stall counter saturation
    out_ready = 1'b0;
    beat(32'h3040);
    tick();
    chk("sat_start", stall_cnt, 16'h0);
    in_valid = 1'b0;
    repeat (65534) tick();
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (70000 - 65535) tick();
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_pc", out_pc, 32'h3040);
    chk("sat_occ", occupancy, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
